// File: rtl/layer_priority_scheduler_pkg.sv
// Shared constants and types for the layer priority scheduler.
package layer_pkg;

    localparam int NUM_LAYERS_DEF = 16;

    // Layer slots as wired by the game's drawing blocks
    localparam int L_MISSILE1 = 0;
    localparam int L_TANK1    = 1;
    localparam int L_MISSILE2 = 2;
    localparam int L_TANK2    = 3;
    localparam int L_BRICK    = 4;
    localparam int L_ELECTION = 5;
    localparam int L_BUFF1    = 6;
    localparam int L_BUFF2    = 7;
    localparam int L_BUFF3    = 8;
    localparam int L_BUFF4    = 9;
    localparam int L_DIGIT1   = 10;
    localparam int L_DIGIT2   = 11;
    localparam int L_DIGIT3   = 12;
    localparam int L_DIGIT4   = 13;

    // RUN: table clean; DIRTY: pending differs, waiting for frame start;
    // COMMIT: single cycle in which pending is copied to active
    typedef enum logic [1:0] {RUN, DIRTY, COMMIT} cfg_state_t;

    typedef logic [$clog2(NUM_LAYERS_DEF)-1:0] rank_t;

endpackage

// File: rtl/layer_priority_scheduler_min_select.sv
// Picks the eligible layer with the smallest rank; equal ranks resolve to
// the lowest layer index because only a strictly smaller rank replaces
// the current best.
module layer_min_select
    import layer_pkg::*;
#(
    parameter int N  = NUM_LAYERS_DEF,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         elig,
    input  logic [N-1:0][LW-1:0] ranks,
    output logic [LW-1:0]        win,
    output logic                 found
);

    logic [LW-1:0] best;

    // Ascending-index scan for the minimum rank among eligible layers
    always_comb begin
        win   = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!found || (ranks[i] < best))) begin
                win   = LW'(i);
                best  = ranks[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_priority_scheduler.sv
// Per-pixel layer arbiter with a frame-synchronous reprogrammable rank
// table and frame-counter driven blinking.
module layer_priority_scheduler
    import layer_pkg::*;
#(
    parameter int  NUM_LAYERS   = NUM_LAYERS_DEF,
    parameter int  BLINK_FRAMES = 16,
    localparam int LW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   drawReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [7:0]              backGroundRGB,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [LW-1:0]           cfgLayer,
    input  logic [LW-1:0]           cfgRank,
    input  logic [NUM_LAYERS-1:0]   blinkMask,
    output logic [7:0]              rgbOut,
    output logic [LW-1:0]           selLayer,
    output logic                    selValid,
    output logic                    blinkPhase
);

    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    cfg_state_t                    state, state_nxt;
    logic [NUM_LAYERS-1:0][LW-1:0] rank_act, rank_pend;
    logic [FCW-1:0]                frame_cnt;
    logic                          accept;
    logic                          layer_ok;
    logic [NUM_LAYERS-1:0]         elig;
    logic [LW-1:0]                 win;
    logic                          found;

    assign cfgReady = (state != COMMIT);
    assign accept   = cfgValid & cfgReady;
    // Out-of-range indices only exist for non-power-of-2 layer counts
    assign layer_ok = (int'(cfgLayer) < NUM_LAYERS);
    assign elig     = drawReq & ~(blinkMask & {NUM_LAYERS{blinkPhase}});

    // Config FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= RUN;
        else         state <= state_nxt;
    end

    // Next state: a write coinciding with frame start commits immediately
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (accept) state_nxt = startOfFrame ? COMMIT : DIRTY;
            DIRTY:   if (startOfFrame) state_nxt = COMMIT;
            COMMIT:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Rank tables: writes land in pending, active follows only on COMMIT
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                rank_pend[i] <= LW'(i);
                rank_act[i]  <= LW'(i);
            end
        end else begin
            if (accept && layer_ok) rank_pend[cfgLayer] <= cfgRank;
            if (state == COMMIT)    rank_act <= rank_pend;
        end
    end

    // Frame counter; phase flips as the counter wraps
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt  <= '0;
            blinkPhase <= 1'b0;
        end else if (startOfFrame) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt  <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frame_cnt  <= frame_cnt + FCW'(1);
            end
        end
    end

    layer_min_select #(.N(NUM_LAYERS), .LW(LW)) u_min_select (
        .elig  (elig),
        .ranks (rank_act),
        .win   (win),
        .found (found)
    );

    // Registered pixel output; background when no layer is eligible
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgbOut   <= '0;
            selLayer <= '0;
            selValid <= 1'b0;
        end else if (found) begin
            rgbOut   <= layerRGB[{win, 3'b000} +: 8];
            selLayer <= win;
            selValid <= 1'b1;
        end else begin
            rgbOut   <= backGroundRGB;
            selLayer <= '0;
            selValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_priority_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// a rank-search reference model.
module tb_layer_priority_scheduler;

    localparam int N  = 16;
    localparam int LW = 4;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           resetN;
    logic           startOfFrame;
    logic [N-1:0]   drawReq;
    logic [N*8-1:0] layerRGB;
    logic [7:0]     backGroundRGB;
    logic           cfgValid;
    logic           cfgReady;
    logic [LW-1:0]  cfgLayer;
    logic [LW-1:0]  cfgRank;
    logic [N-1:0]   blinkMask;
    logic [7:0]     rgbOut;
    logic [LW-1:0]  selLayer;
    logic           selValid;
    logic           blinkPhase;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int m_act[N];
    int m_pend[N];
    bit m_dirty, m_commit;
    int m_frames;

    // expectations for the most recent step
    logic [7:0] e_rgb;
    int         e_sel;
    logic       e_vld, e_rdy, a_rdy, e_ph;

    always #5 clk = ~clk;

    layer_priority_scheduler #(.NUM_LAYERS(N), .BLINK_FRAMES(BF)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .drawReq       (drawReq),
        .layerRGB      (layerRGB),
        .backGroundRGB (backGroundRGB),
        .cfgValid      (cfgValid),
        .cfgReady      (cfgReady),
        .cfgLayer      (cfgLayer),
        .cfgRank       (cfgRank),
        .blinkMask     (blinkMask),
        .rgbOut        (rgbOut),
        .selLayer      (selLayer),
        .selValid      (selValid),
        .blinkPhase    (blinkPhase)
    );

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = i;
            m_pend[i] = i;
        end
        m_dirty  = 0;
        m_commit = 0;
        m_frames = 0;
    endtask

    // One clock: compute expectation from current inputs, advance model,
    // return at posedge+1 with outputs settled.
    task automatic step();
        int  w;
        int  ph;
        bit  acc;
        #3;
        ph    = (m_frames / BF) % 2;
        e_rdy = !m_commit;
        a_rdy = cfgReady;
        w     = -1;
        for (int r = 0; r < N && w < 0; r++)
            for (int i = 0; i < N && w < 0; i++)
                if (drawReq[i] && !(blinkMask[i] && ph != 0) && m_act[i] == r) w = i;
        e_vld = (w >= 0);
        e_sel = (w >= 0) ? w : 0;
        e_rgb = (w >= 0) ? layerRGB[w*8 +: 8] : backGroundRGB;
        acc   = cfgValid && e_rdy;
        @(posedge clk);
        if (m_commit) begin
            m_act    = m_pend;
            m_commit = 0;
        end
        if (acc) begin
            m_pend[cfgLayer] = int'(cfgRank);
            m_dirty = 1;
        end
        if (startOfFrame) begin
            m_frames++;
            if (m_dirty) begin
                m_commit = 1;
                m_dirty  = 0;
            end
        end
        #1;
        e_ph = ((m_frames / BF) % 2) != 0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        m_reset();
        drawReq = 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rgbOut !== 8'h00) $display("FAIL rst_rgb: got %0h want 0", rgbOut); else n_pass++;
        n_chk++; if (selLayer !== 4'd0) $display("FAIL rst_sel: got %0d want 0", selLayer); else n_pass++;
        n_chk++; if (selValid !== 1'b0) $display("FAIL rst_vld: got %0b want 0", selValid); else n_pass++;
        n_chk++; if (blinkPhase !== 1'b0) $display("FAIL rst_phase: got %0b want 0", blinkPhase); else n_pass++;
        resetN = 1'b1;
        #1;
        n_chk++; if (cfgReady !== 1'b1) $display("FAIL rst_ready: got %0b want 1", cfgReady); else n_pass++;
        step();
        n_chk++; if (rgbOut !== 8'hE0) $display("FAIL dflt_rgb: got %0h want e0", rgbOut); else n_pass++;
        n_chk++; if (selLayer !== 4'd0) $display("FAIL dflt_sel: got %0d want 0", selLayer); else n_pass++;
        n_chk++; if (selValid !== 1'b1) $display("FAIL dflt_vld: got %0b want 1", selValid); else n_pass++;
    endtask

    task automatic test_background();
        drawReq = '0;
        backGroundRGB = 8'h49;
        step();
        n_chk++; if (rgbOut !== 8'h49) $display("FAIL bg_rgb: got %0h want 49", rgbOut); else n_pass++;
        n_chk++; if (selValid !== 1'b0) $display("FAIL bg_vld: got %0b want 0", selValid); else n_pass++;
        n_chk++; if (selLayer !== 4'd0) $display("FAIL bg_sel: got %0d want 0", selLayer); else n_pass++;
    endtask

    task automatic test_deferred();
        drawReq  = 16'h0003;
        cfgValid = 1'b1; cfgLayer = 4'd1; cfgRank = 4'd0;
        step();
        cfgLayer = 4'd0; cfgRank = 4'd5;
        step();
        n_chk++; if (selLayer !== 4'd0) $display("FAIL defer_hold0: got %0d want 0", selLayer); else n_pass++;
        cfgValid = 1'b0;
        step(); step();
        n_chk++; if (selLayer !== 4'd0) $display("FAIL defer_hold1: got %0d want 0", selLayer); else n_pass++;
        startOfFrame = 1'b1;
        step();
        n_chk++; if (a_rdy !== 1'b1) $display("FAIL defer_rdy_sof: got %0b want 1", a_rdy); else n_pass++;
        n_chk++; if (selLayer !== 4'd0) $display("FAIL defer_sof_sel: got %0d want 0", selLayer); else n_pass++;
        startOfFrame = 1'b0;
        step();
        n_chk++; if (a_rdy !== 1'b0) $display("FAIL defer_rdy_commit: got %0b want 0", a_rdy); else n_pass++;
        n_chk++; if (selLayer !== 4'd0) $display("FAIL defer_commit_sel: got %0d want 0", selLayer); else n_pass++;
        step();
        n_chk++; if (a_rdy !== 1'b1) $display("FAIL defer_rdy_after: got %0b want 1", a_rdy); else n_pass++;
        n_chk++; if (selLayer !== 4'd1) $display("FAIL defer_new_sel: got %0d want 1", selLayer); else n_pass++;
        n_chk++; if (rgbOut !== 8'h1C) $display("FAIL defer_new_rgb: got %0h want 1c", rgbOut); else n_pass++;
    endtask

    task automatic test_tiebreak();
        // rank[0]=0 and rank[3]=0, each written in its frame-start cycle
        for (int k = 0; k < 2; k++) begin
            cfgValid = 1'b1; startOfFrame = 1'b1;
            cfgLayer = (k == 0) ? 4'd0 : 4'd3; cfgRank = 4'd0;
            step();
            cfgValid = 1'b0; startOfFrame = 1'b0;
            step(); step();
        end
        drawReq = 16'h0009;
        step();
        n_chk++; if (selLayer !== 4'd0) $display("FAIL tie_09: got %0d want 0", selLayer); else n_pass++;
        drawReq = 16'h000C;
        step();
        n_chk++; if (selLayer !== 4'd3) $display("FAIL tie_0c: got %0d want 3", selLayer); else n_pass++;
        drawReq = 16'h000A;
        step();
        n_chk++; if (selLayer !== 4'd1) $display("FAIL tie_0a: got %0d want 1", selLayer); else n_pass++;
    endtask

    task automatic test_blink();
        int ph;
        do_reset();
        drawReq = 16'h0003; blinkMask = 16'h0001;
        for (int f = 0; f < 8; f++) begin
            ph = (f / 2) % 2;
            step(); step();
            n_chk++; if (selLayer !== 4'(ph)) $display("FAIL blink_sel f%0d: got %0d want %0d", f, selLayer, ph); else n_pass++;
            n_chk++; if (blinkPhase !== ph[0]) $display("FAIL blink_phase f%0d: got %0b want %0b", f, blinkPhase, ph[0]); else n_pass++;
            if (f == 2) begin
                blinkMask = '0;
                step();
                n_chk++; if (selLayer !== 4'd0) $display("FAIL blink_live: got %0d want 0", selLayer); else n_pass++;
                blinkMask = 16'h0001;
            end
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
        end
        blinkMask = '0;
    endtask

    task automatic test_reset_dirty();
        do_reset();
        drawReq = 16'h0003;
        cfgValid = 1'b1; cfgLayer = 4'd1; cfgRank = 4'd0;
        step();
        cfgLayer = 4'd0; cfgRank = 4'd7;
        step();
        cfgValid = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        n_chk++; if (selValid !== 1'b0) $display("FAIL rstd_async: got %0b want 0", selValid); else n_pass++;
        do_reset();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        n_chk++; if (a_rdy !== 1'b1) $display("FAIL rstd_nocommit: got %0b want 1", a_rdy); else n_pass++;
        step(); step();
        n_chk++; if (selLayer !== 4'd0) $display("FAIL rstd_sel: got %0d want 0", selLayer); else n_pass++;
        n_chk++; if (rgbOut !== 8'hE0) $display("FAIL rstd_rgb: got %0h want e0", rgbOut); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) layerRGB[i*8 +: 8] = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            drawReq       = 16'($urandom) & 16'($urandom);
            blinkMask     = 16'($urandom) & 16'($urandom);
            backGroundRGB = 8'($urandom);
            startOfFrame  = ($urandom_range(0, 9) == 0);
            cfgValid      = ($urandom_range(0, 3) == 0);
            cfgLayer      = 4'($urandom_range(0, N-1));
            cfgRank       = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, N-1));
            step();
            n_chk++; if (rgbOut !== e_rgb) $display("FAIL rnd_rgb c%0d: got %0h want %0h", c, rgbOut, e_rgb); else n_pass++;
            n_chk++; if (selLayer !== 4'(e_sel)) $display("FAIL rnd_sel c%0d: got %0d want %0d", c, selLayer, e_sel); else n_pass++;
            n_chk++; if (selValid !== e_vld) $display("FAIL rnd_vld c%0d: got %0b want %0b", c, selValid, e_vld); else n_pass++;
            n_chk++; if (a_rdy !== e_rdy) $display("FAIL rnd_rdy c%0d: got %0b want %0b", c, a_rdy, e_rdy); else n_pass++;
            n_chk++; if (blinkPhase !== e_ph) $display("FAIL rnd_phase c%0d: got %0b want %0b", c, blinkPhase, e_ph); else n_pass++;
        end
        cfgValid = 1'b0; startOfFrame = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; drawReq = '0; blinkMask = '0;
        backGroundRGB = 8'h00; cfgValid = 1'b0; cfgLayer = '0; cfgRank = '0;
        for (int i = 0; i < N; i++) layerRGB[i*8 +: 8] = 8'(i * 17 + 3);
        layerRGB[7:0]  = 8'hE0;
        layerRGB[15:8] = 8'h1C;
        m_reset();

        test_reset();
        test_background();
        test_deferred();
        test_tiebreak();
        test_blink();
        test_reset_dirty();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
